// File: rtl/cmp_arb_pkg.sv
// Shared types and helpers for the round-robin comparator arbiter.
// Holds the FSM encoding, the statistics counter width and the pointer wrap helper.
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmp  = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned STAT_W = 16;

    // Next round-robin pointer after granting 'ptr', wrapping modulo r.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned r);
        if (ptr + 1 >= r) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping modulo R.
// ptr must be below R; grant is one-hot or zero.
module rr_pick #(
    parameter int unsigned R   = 4,
    parameter int unsigned IDW = $clog2(R)
) (
    input  logic [R-1:0]   valid,
    input  logic [IDW-1:0] ptr,
    output logic [R-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           any
);

    logic [IDW:0] sum;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        for (int unsigned i = 0; i < R; i++) begin
            // ptr + i < 2R, so a single conditional subtract is a full modulo.
            sum = {1'b0, ptr} + (IDW + 1)'(i);
            if (sum >= (IDW + 1)'(R)) begin
                sum = sum - (IDW + 1)'(R);
            end
            if (!any && valid[sum[IDW-1:0]]) begin
                any                   = 1'b1;
                grant[sum[IDW-1:0]]   = 1'b1;
                grant_idx             = sum[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/cmp_rr_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator among R requesters.
// Optional feature macro CMP_ARB_STATS_EN adds saturating stat_done / stat_wait counters.
module cmp_rr_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned R     = 4,
    localparam int unsigned IDW  = $clog2(R)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [R-1:0]        req_valid,
    input  logic [R*N-1:0]      req_a,
    input  logic [R*N-1:0]      req_b,
    output logic [R-1:0]        req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic                rsp_eq,
    output logic                rsp_lt,
    output logic                rsp_gt
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_done,
    output logic [STAT_W-1:0]   stat_wait
`endif
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q;
    logic [N-1:0]     a_q, b_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   rsp_id_q;
    logic             rsp_eq_q, rsp_lt_q, rsp_gt_q;

    logic [R-1:0]     pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             accept;
    logic             rsp_fire;
    logic [N-1:0]     win_a, win_b;
    logic             cmp_eq, cmp_lt, cmp_gt;

    rr_pick #(
        .R   (R),
        .IDW (IDW)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_any) state_d = StCmp;
            StCmp:   state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; ready is gated by rst so nothing is accepted while reset is held.
    always_comb begin
        accept    = (state_q == StIdle) && pick_any && !rst;
        req_ready = accept ? pick_grant : '0;
        rsp_valid = (state_q == StResp);
        rsp_fire  = rsp_valid && rsp_ready;
    end

    always_comb begin
        win_a  = N'(req_a >> (pick_idx * N));
        win_b  = N'(req_b >> (pick_idx * N));
        cmp_eq = (a_q == b_q);
        cmp_lt = (a_q < b_q);
        cmp_gt = !cmp_eq && !cmp_lt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            rsp_id_q <= '0;
            rsp_eq_q <= 1'b0;
            rsp_lt_q <= 1'b0;
            rsp_gt_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= win_a;
                b_q   <= win_b;
                id_q  <= pick_idx;
                ptr_q <= IDW'(rr_next(32'(pick_idx), R));
            end
            if (state_q == StCmp) begin
                rsp_id_q <= id_q;
                rsp_eq_q <= cmp_eq;
                rsp_lt_q <= cmp_lt;
                rsp_gt_q <= cmp_gt;
            end
        end
    end

    assign rsp_id = rsp_id_q;
    assign rsp_eq = rsp_eq_q;
    assign rsp_lt = rsp_lt_q;
    assign rsp_gt = rsp_gt_q;

`ifdef CMP_ARB_STATS_EN
    logic [STAT_W-1:0] done_q, wait_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= '0;
            wait_q <= '0;
        end else begin
            if (rsp_fire && (done_q != '1)) begin
                done_q <= done_q + STAT_W'(1);
            end
            if ((|req_valid) && (state_q != StIdle) && (wait_q != '1)) begin
                wait_q <= wait_q + STAT_W'(1);
            end
        end
    end

    assign stat_done = done_q;
    assign stat_wait = wait_q;
`endif

endmodule

// File: doc/cmp_rr_arbiter.md
Name: cmp_rr_arbiter

Overview:
Shares one N-bit unsigned magnitude comparator among R requesters using round-robin arbitration.
Each requester presents an operand pair with a valid/ready handshake. The block latches the winning pair, compares it, and returns registered eq/lt/gt results tagged with the requester id on one shared response channel that supports backpressure.
It sits between the requester clients and the comparator datapath.

Parameters:
N, 4, operand width in bits (N >= 1)
R, 4, number of requesters (R >= 2; non-power-of-2 allowed)
IDW, $clog2(R), requester id width (derived, localparam)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  R  per-requester request valid
req_a  input  R*N  packed operand A; requester i uses bits [i*N +: N]
req_b  input  R*N  packed operand B; same packing as req_a
req_ready  output  R  per-requester accept, at most one bit high
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  IDW  index of the requester that owns the response
rsp_eq  output  1  A == B
rsp_lt  output  1  A < B (unsigned)
rsp_gt  output  1  A > B (unsigned)

Behaviour:
- Reset: state=IDLE, rr pointer=0, rsp_valid=0, rsp_id=0, rsp_eq/lt/gt=0. req_ready is forced to 0 whenever rst=1.
- FSM states:
  - IDLE: if no req_valid is high, stay in IDLE. Otherwise pick the winner as the first requester with req_valid=1, scanning ptr, ptr+1, ... and wrapping modulo R. req_ready[winner]=1 combinationally in the same cycle, so the handshake completes that cycle. Latch req_a/req_b of the winner and latch the winner id. Set ptr <= (winner+1) mod R. Next state is CMP.
  - CMP: one cycle. Compute eq/lt/gt from the latched operands and register them into rsp_eq/lt/gt, with rsp_id = latched id. Next state is RESP, with rsp_valid=1 from the next cycle.
  - RESP: rsp_valid=1. rsp_id, rsp_eq, rsp_lt and rsp_gt stay stable until rsp_valid && rsp_ready. On that handshake: rsp_valid <= 0, next state is IDLE.
- Latency: request acceptance to rsp_valid is 2 cycles. Minimum spacing between accepts is 3 cycles, i.e. one transaction per 3 cycles with no backpressure.
- req_ready is 0 in CMP and RESP. It is one-hot or zero, never multi-hot.
- Requesters hold req_valid and their operands until req_ready. The arbiter does not check for a dropped request.
- In any valid response exactly one of rsp_eq/lt/gt is 1. For N=1 the comparison degenerates to a single-bit compare.
- Pointer wrap: after granting R-1, the pointer returns to 0. No requester waits more than R-1 other grants.
- Requests arriving during CMP/RESP are not accepted. They are arbitrated on the next IDLE cycle using the updated pointer.
- Reset mid-operation (any state): the next cycle is IDLE, the in-flight transaction is discarded, and no response is issued.

Optional Feature:
CMP_ARB_STATS_EN
- When defined, adds output stat_done [15:0]: count of completed response handshakes. Resets to 0 and saturates at 16'hFFFF with no wrap. Also adds output stat_wait [15:0]: count of cycles with any req_valid high while state != IDLE. Same reset and saturation rules.
- When undefined, neither port nor its logic exists. All other behaviour is identical.

Decomposition:
- Package cmp_arb_pkg:
  - state enum {IDLE, CMP, RESP}, 2-bit encoding
  - STAT_W=16 constant
  - helper function rr_next(ptr, R) for the wrap computation
- Sub-module rr_pick: combinational round-robin picker. Inputs valid[R] and ptr. Outputs grant onehot[R], grant_idx[IDW] and any. It is instantiated once in cmp_rr_arbiter.
- The comparison itself is plain combinational logic in the top.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, rsp_id=0, eq/lt/gt=0 throughout.
2. Single request, requester 1, a=9, b=3, rsp_ready=1 -> req_ready=4'b0010 at cycle 0; rsp_valid=1 at cycle 2 with rsp_id=1, gt=1, eq=0, lt=0; rsp_valid=0 at cycle 3.
3. All four requesting continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1. Accepts occur every 3 cycles, and rsp_id follows the same order.
4. Backpressure: requester 2 with a=5, b=5; rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_id=2 and eq=1 are held stable, req_ready=0 throughout even with other valids high. With rsp_ready=1, the next grant happens 1 cycle after the handshake.
5. Magnitude cases:
   - a=2, b=14 -> lt
   - a=8, b=7 -> gt (MSB decides)
   - a=0, b=0 -> eq
   - a=15, b=15 -> eq
6. rst pulsed during RESP with ptr=3 -> next cycle rsp_valid=0. The next contest with valid=4'b1111 grants requester 0. With CMP_ARB_STATS_EN, stat_done resets to 0 and increments once per handshake.
